decode_sequencer: RTL and testbench

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

---
 rtl/decode_sequencer_pkg.sv | 100 ++++++++++
 rtl/decode_sequencer_if.sv | 43 ++++
 rtl/decode_sequencer_opcode_decode.sv | 66 ++++++
 rtl/decode_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_decode_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/decode_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// decode_sequencer_pkg
// Purpose : shared constants for the decode sequencer slice. Holds opcode
//           values, ALU operation codes, ctrl bit-field positions, the
//           sequencer state enum and the single-cycle decode record.
// Ports   : none (package).
// Config  : DECODE_SEQ_IRQ_EN is consumed by decode_sequencer, not here.
// ---------------------------------------------------------------------------
package decode_sequencer_pkg;

  localparam int CTRL_W = 10;
  localparam int ALU_W  = 5;

  // Bit positions inside ctrl = {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
  localparam int CTRL_IR      = 9;
  localparam int CTRL_IW      = 8;
  localparam int CTRL_MR      = 7;
  localparam int CTRL_MW      = 6;
  localparam int CTRL_MTR     = 5;
  localparam int CTRL_ALU_SRC = 4;
  localparam int CTRL_RW      = 3;
  localparam int CTRL_BRANCH  = 2;
  localparam int CTRL_SETC    = 1;
  localparam int CTRL_CLRC    = 0;

  // Register-to-register ALU instruction: write back the ALU result only.
  localparam logic [CTRL_W-1:0] ALU_SIGNALS = 10'b0000001000;
  // LDM immediate cycle: immediate operand into the ALU, then write back.
  localparam logic [CTRL_W-1:0] LDM_SIGNALS = 10'b0000011000;

  // Opcodes
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_SETC = 5'd1;
  localparam logic [4:0] OP_CLRC = 5'd2;
  localparam logic [4:0] OP_NOT  = 5'd3;
  localparam logic [4:0] OP_INC  = 5'd4;
  localparam logic [4:0] OP_DEC  = 5'd5;
  localparam logic [4:0] OP_OUT  = 5'd6;
  localparam logic [4:0] OP_IN   = 5'd7;
  localparam logic [4:0] OP_MOV  = 5'd8;
  localparam logic [4:0] OP_ADD  = 5'd9;
  localparam logic [4:0] OP_SUB  = 5'd10;
  localparam logic [4:0] OP_AND  = 5'd11;
  localparam logic [4:0] OP_OR   = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_SHR  = 5'd14;
  localparam logic [4:0] OP_PUSH = 5'd15;
  localparam logic [4:0] OP_POP  = 5'd16;
  localparam logic [4:0] OP_LDM  = 5'd17;
  localparam logic [4:0] OP_LDD  = 5'd18;
  localparam logic [4:0] OP_STD  = 5'd19;
  localparam logic [4:0] OP_JZ   = 5'd20;
  localparam logic [4:0] OP_JN   = 5'd21;
  localparam logic [4:0] OP_JC   = 5'd22;
  localparam logic [4:0] OP_JMP  = 5'd23;
  localparam logic [4:0] OP_CALL = 5'd24;
  localparam logic [4:0] OP_RET  = 5'd25;
  localparam logic [4:0] OP_RTI  = 5'd26;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_NOP = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'd2;
  localparam logic [ALU_W-1:0] ALU_AND = 5'd3;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'd4;
  localparam logic [ALU_W-1:0] ALU_NOT = 5'd5;
  localparam logic [ALU_W-1:0] ALU_INC = 5'd6;
  localparam logic [ALU_W-1:0] ALU_DEC = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SHL = 5'd8;
  localparam logic [ALU_W-1:0] ALU_SHR = 5'd9;
  localparam logic [ALU_W-1:0] ALU_MOV = 5'd10;
  localparam logic [ALU_W-1:0] ALU_STD = 5'd11;

  // Stack operation encodings for push_pop
  localparam logic [1:0] PP_NONE = 2'b00;
  localparam logic [1:0] PP_PUSH = 2'b01;
  localparam logic [1:0] PP_POP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LDM_IMM,
    PUSH_PC,
    POP_PC,
    FLUSH
  } seq_state_t;

  // Result of the single-cycle opcode table
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ALU_W-1:0]  alu_op;
    logic [1:0]        push_pop;
    logic              is_push;
    logic              is_in;
  } dec_t;

  function automatic logic [CTRL_W-1:0] ctrlBit(input int pos);
    return CTRL_W'(1) << pos;
  endfunction

endpackage

// File: rtl/decode_sequencer_if.sv
// ---------------------------------------------------------------------------
// decode_sequencer_if
// Purpose : bundles the decode-stage inputs and control outputs of the
//           decode sequencer.
// Signals : opcode/instr_valid/bubble/irq  - from F2D buffer, hazard unit, IRQ
//           ctrl/alu_op/push_pop/word_idx  - datapath and stack control
//           imm_phase/hold_fetch/squash    - pipeline sequencing
//           ccr_save/ccr_restore/is_push/is_in - CCR and data selects
// Modports: master (producer of inputs, e.g. a bench), slave (the sequencer).
// ---------------------------------------------------------------------------
interface decode_sequencer_if
  import decode_sequencer_pkg::*;
#(
  parameter int OPC_W = 5
);
  logic [OPC_W-1:0]  opcode;
  logic              instr_valid;
  logic              bubble;
  logic              irq;
  logic [CTRL_W-1:0] ctrl;
  logic [ALU_W-1:0]  alu_op;
  logic [1:0]        push_pop;
  logic [1:0]        word_idx;
  logic              imm_phase;
  logic              hold_fetch;
  logic              squash;
  logic              ccr_save;
  logic              ccr_restore;
  logic              is_push;
  logic              is_in;

  modport master (
    output opcode, instr_valid, bubble, irq,
    input  ctrl, alu_op, push_pop, word_idx, imm_phase, hold_fetch,
           squash, ccr_save, ccr_restore, is_push, is_in
  );

  modport slave (
    input  opcode, instr_valid, bubble, irq,
    output ctrl, alu_op, push_pop, word_idx, imm_phase, hold_fetch,
           squash, ccr_save, ccr_restore, is_push, is_in
  );
endinterface

// File: rtl/decode_sequencer_opcode_decode.sv
// ---------------------------------------------------------------------------
// seq_opcode_decode
// Purpose : purely combinational table for single-cycle opcodes. Sequenced
//           opcodes (LDM, CALL, RET, RTI) and unknown opcodes come out as NOP;
//           the sequencer FSM overrides them.
// Ports   : i_opcode - opcode from the F2D buffer
//           o_dec    - ctrl, alu_op, push_pop, is_push, is_in for that opcode
// ---------------------------------------------------------------------------
module seq_opcode_decode
  import decode_sequencer_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] i_opcode,
  output dec_t             o_dec
);

  // Opcode table; anything not listed falls through as NOP.
  always_comb begin
    o_dec        = '0;
    o_dec.alu_op = ALU_NOP;
    case (i_opcode)
      OPC_W'(OP_SETC): o_dec.ctrl = ctrlBit(CTRL_SETC);
      OPC_W'(OP_CLRC): o_dec.ctrl = ctrlBit(CTRL_CLRC);
      OPC_W'(OP_NOT):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_NOT; end
      OPC_W'(OP_INC):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_INC; end
      OPC_W'(OP_DEC):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_DEC; end
      OPC_W'(OP_MOV):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_MOV; end
      OPC_W'(OP_ADD):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_ADD; end
      OPC_W'(OP_SUB):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_SUB; end
      OPC_W'(OP_AND):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_AND; end
      OPC_W'(OP_OR):   begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_OR;  end
      OPC_W'(OP_SHL):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_SHL; end
      OPC_W'(OP_SHR):  begin o_dec.ctrl = ALU_SIGNALS; o_dec.alu_op = ALU_SHR; end
      OPC_W'(OP_OUT):  begin o_dec.ctrl = ctrlBit(CTRL_IW); o_dec.alu_op = ALU_MOV; end
      OPC_W'(OP_IN): begin
        o_dec.ctrl   = ctrlBit(CTRL_IR) | ctrlBit(CTRL_RW);
        o_dec.alu_op = ALU_MOV;
        o_dec.is_in  = 1'b1;
      end
      OPC_W'(OP_PUSH): begin
        o_dec.ctrl     = ctrlBit(CTRL_MW);
        o_dec.alu_op   = ALU_STD;
        o_dec.push_pop = PP_PUSH;
        o_dec.is_push  = 1'b1;
      end
      OPC_W'(OP_POP): begin
        o_dec.ctrl     = ctrlBit(CTRL_MR) | ctrlBit(CTRL_MTR) | ctrlBit(CTRL_RW);
        o_dec.push_pop = PP_POP;
      end
      OPC_W'(OP_LDD): begin
        o_dec.ctrl   = ctrlBit(CTRL_MR) | ctrlBit(CTRL_MTR) |
                       ctrlBit(CTRL_ALU_SRC) | ctrlBit(CTRL_RW);
        o_dec.alu_op = ALU_ADD;
      end
      OPC_W'(OP_STD): begin
        o_dec.ctrl   = ctrlBit(CTRL_MW) | ctrlBit(CTRL_ALU_SRC);
        o_dec.alu_op = ALU_STD;
      end
      OPC_W'(OP_JZ), OPC_W'(OP_JN), OPC_W'(OP_JC), OPC_W'(OP_JMP):
        o_dec.ctrl = ctrlBit(CTRL_BRANCH);
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// ---------------------------------------------------------------------------
// decode_sequencer
// Purpose : decode-stage control unit with a small FSM for multi-cycle
//           instructions (LDM immediate, CALL push, RET/RTI pop + flush) and
//           interrupt entry.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - decode_sequencer_if.slave (opcode/valid/bubble/irq in,
//                   control outputs out)
// Params  : PC_WORDS (1..4) stack words per saved PC,
//           FLUSH_DEPTH (1..7) squash cycles after RET/RTI, OPC_W opcode width.
// Config  : define DECODE_SEQ_IRQ_EN to build irq handling, the pending flag,
//           ccr_save and ccr_restore; without it irq is ignored and RTI acts
//           as RET.
// ---------------------------------------------------------------------------
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int PC_WORDS    = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int OPC_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_sequencer_if.slave   bus
);

  localparam logic [1:0] LAST_WORD  = 2'(PC_WORDS - 1);
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_DEPTH - 1);

  seq_state_t r_state;
  logic [1:0] r_wordCnt;
  logic [2:0] r_flushCnt;

  dec_t w_dec;
  logic w_idleValid, w_irqTake;
  logic w_opCall, w_opRet, w_opRti, w_opLdm, w_isRet;

  logic [CTRL_W-1:0] w_ctrl;
  logic [ALU_W-1:0]  w_aluOp;
  logic [1:0]        w_pushPop, w_wordIdx;
  logic w_immPhase, w_holdFetch, w_squash, w_ccrSave, w_ccrRestore;
  logic w_isPush, w_isIn;

  seq_opcode_decode #(.OPC_W(OPC_W)) u_decode (
    .i_opcode (bus.opcode),
    .o_dec    (w_dec)
  );

  assign w_idleValid = bus.instr_valid && !bus.bubble;
  assign w_opCall    = (bus.opcode == OPC_W'(OP_CALL));
  assign w_opRet     = (bus.opcode == OPC_W'(OP_RET));
  assign w_opRti     = (bus.opcode == OPC_W'(OP_RTI));
  assign w_opLdm     = (bus.opcode == OPC_W'(OP_LDM));
  assign w_isRet     = w_opRet || w_opRti;

`ifdef DECODE_SEQ_IRQ_EN
  logic r_irqPend, r_isRti;

  // Interrupts are only taken at an IDLE instruction boundary; a request
  // seen mid-sequence is remembered until then.
  assign w_irqTake = (r_state == IDLE) && (bus.irq || r_irqPend);

  // Pending-interrupt flag and RTI marker for the pop sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irqPend <= 1'b0;
      r_isRti   <= 1'b0;
    end else begin
      if (w_irqTake)
        r_irqPend <= 1'b0;
      else if (bus.irq && (r_state != IDLE))
        r_irqPend <= 1'b1;
      if ((r_state == IDLE) && !w_irqTake && w_idleValid && w_isRet)
        r_isRti <= w_opRti;
    end
  end
`else
  assign w_irqTake = 1'b0;
`endif

  // Sequencer state and counters. A call (or interrupt) pushes word 0 from
  // the IDLE decode cycle itself so the branch happens with the instruction;
  // returns use the IDLE cycle to dispatch and do every pop in POP_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wordCnt  <= '0;
      r_flushCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_irqTake || (w_idleValid && w_opCall)) begin
            if (PC_WORDS > 1) begin
              r_state   <= PUSH_PC;
              r_wordCnt <= 2'd1;
            end
          end else if (w_idleValid && w_isRet) begin
            r_state   <= POP_PC;
            r_wordCnt <= LAST_WORD;
          end else if (w_idleValid && w_opLdm) begin
            r_state <= LDM_IMM;
          end
        end
        LDM_IMM: r_state <= IDLE;
        PUSH_PC: begin
          if (r_wordCnt == LAST_WORD) begin
            r_state   <= IDLE;
            r_wordCnt <= '0;
          end else begin
            r_wordCnt <= r_wordCnt + 2'd1;
          end
        end
        POP_PC: begin
          if (r_wordCnt == '0) begin
            r_state    <= FLUSH;
            r_flushCnt <= '0;
          end else begin
            r_wordCnt <= r_wordCnt - 2'd1;
          end
        end
        FLUSH: begin
          if (r_flushCnt == FLUSH_LAST) begin
            r_state    <= IDLE;
            r_flushCnt <= '0;
          end else begin
            r_flushCnt <= r_flushCnt + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode from state, counters and opcode. rst_n gates everything to
  // zero so outputs are quiet during reset without waiting for a clock.
  always_comb begin
    w_ctrl       = '0;
    w_aluOp      = ALU_NOP;
    w_pushPop    = PP_NONE;
    w_wordIdx    = '0;
    w_immPhase   = 1'b0;
    w_holdFetch  = 1'b0;
    w_squash     = 1'b0;
    w_ccrSave    = 1'b0;
    w_ccrRestore = 1'b0;
    w_isPush     = 1'b0;
    w_isIn       = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_irqTake) begin
            w_ctrl      = ctrlBit(CTRL_MW);
            w_pushPop   = PP_PUSH;
            w_holdFetch = (PC_WORDS > 1);
            w_ccrSave   = 1'b1;
          end else if (w_idleValid) begin
            if (w_opCall) begin
              w_ctrl      = ctrlBit(CTRL_MW) | ctrlBit(CTRL_BRANCH);
              w_aluOp     = ALU_STD;
              w_pushPop   = PP_PUSH;
              w_holdFetch = (PC_WORDS > 1);
            end else if (!w_isRet && !w_opLdm) begin
              w_ctrl    = w_dec.ctrl;
              w_aluOp   = w_dec.alu_op;
              w_pushPop = w_dec.push_pop;
              w_isPush  = w_dec.is_push;
              w_isIn    = w_dec.is_in;
            end
          end
        end
        LDM_IMM: begin
          w_ctrl     = LDM_SIGNALS;
          w_aluOp    = ALU_MOV;
          w_immPhase = 1'b1;
        end
        PUSH_PC: begin
          w_ctrl      = ctrlBit(CTRL_MW);
          w_pushPop   = PP_PUSH;
          w_wordIdx   = r_wordCnt;
          w_holdFetch = (r_wordCnt != LAST_WORD);
        end
        POP_PC: begin
          w_ctrl    = ctrlBit(CTRL_MR);
          w_pushPop = PP_POP;
          w_wordIdx = r_wordCnt;
`ifdef DECODE_SEQ_IRQ_EN
          w_ccrRestore = r_isRti && (r_wordCnt == '0);
`endif
        end
        FLUSH: w_squash = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ctrl        = w_ctrl;
  assign bus.alu_op      = w_aluOp;
  assign bus.push_pop    = w_pushPop;
  assign bus.word_idx    = w_wordIdx;
  assign bus.imm_phase   = w_immPhase;
  assign bus.hold_fetch  = w_holdFetch;
  assign bus.squash      = w_squash;
  assign bus.ccr_save    = w_ccrSave;
  assign bus.ccr_restore = w_ccrRestore;
  assign bus.is_push     = w_isPush;
  assign bus.is_in       = w_isIn;

endmodule

// File: tb/tb_decode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_decode_sequencer
// Purpose : self-checking bench for decode_sequencer (PC_WORDS=2,
//           FLUSH_DEPTH=2). Directed vectors push hand-computed expected
//           outputs into a queue; a monitor compares them one per cycle.
//           Expectations follow DECODE_SEQ_IRQ_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_decode_sequencer;

`ifdef DECODE_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // flags = {imm_phase, hold_fetch, squash, ccr_save, ccr_restore, is_push, is_in}
  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] F_IMM   = 7'b1000000;
  localparam logic [6:0] F_HOLD  = 7'b0100000;
  localparam logic [6:0] F_SQ    = 7'b0010000;
  localparam logic [6:0] F_CSAVE = 7'b0001000;
  localparam logic [6:0] F_CREST = 7'b0000100;
  localparam logic [6:0] F_PUSH  = 7'b0000010;
  localparam logic [6:0] F_IN    = 7'b0000001;

  // Hand-encoded ctrl patterns {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
  localparam logic [9:0] C_ZERO = 10'b0000000000;
  localparam logic [9:0] C_ALU  = 10'b0000001000;
  localparam logic [9:0] C_LDMI = 10'b0000011000;
  localparam logic [9:0] C_MW   = 10'b0001000000;
  localparam logic [9:0] C_CALL = 10'b0001000100;
  localparam logic [9:0] C_MR   = 10'b0010000000;

  logic clk = 1'b0;
  logic rst_n;

  typedef struct {
    string       name;
    logic [25:0] exp;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   failCount  = 0;

  decode_sequencer_if #(.OPC_W(5)) bus ();

  decode_sequencer #(
    .PC_WORDS    (2),
    .FLUSH_DEPTH (2),
    .OPC_W       (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the
  // response expected while those inputs are applied.
  task automatic applyStimulus(input string name, input logic rstVal,
                               input logic [4:0] opc, input logic valid,
                               input logic bub, input logic irqIn,
                               input logic [9:0] ctrl, input logic [4:0] alu,
                               input logic [1:0] pp, input logic [1:0] widx,
                               input logic [6:0] flags);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rstVal;
    bus.opcode      = opc;
    bus.instr_valid = valid;
    bus.bubble      = bub;
    bus.irq         = irqIn;
    e.name = name;
    e.exp  = {ctrl, alu, pp, widx, flags};
    expQ.push_back(e);
  endtask

  // Compare the live outputs against one queued expectation.
  task automatic checkOutput(input exp_t e);
    logic [25:0] act;
    act = {bus.ctrl, bus.alu_op, bus.push_pop, bus.word_idx, bus.imm_phase,
           bus.hold_fetch, bus.squash, bus.ccr_save, bus.ccr_restore,
           bus.is_push, bus.is_in};
    checkCount++;
    if (act !== e.exp) begin
      failCount++;
      $display("[TB] FAIL %s: got ctrl=%b alu=%0d pp=%b widx=%0d flags=%b, expected ctrl=%b alu=%0d pp=%b widx=%0d flags=%b",
               e.name, act[25:16], act[15:11], act[10:9], act[8:7], act[6:0],
               e.exp[25:16], e.exp[15:11], e.exp[10:9], e.exp[8:7], e.exp[6:0]);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Directed vectors: name, rst_n, opcode, valid, bubble, irq, expected outputs
  initial begin
    rst_n           = 1'b0;
    bus.opcode      = 5'd0;
    bus.instr_valid = 1'b0;
    bus.bubble      = 1'b0;
    bus.irq         = 1'b0;

    // Reset holds outputs quiet even with a live ADD presented
    applyStimulus("reset0", 0, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("reset1", 0, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);

    // Single-cycle decode
    applyStimulus("add", 1, 5'd9, 1, 0, 0, C_ALU, 5'd1, 2'b00, 2'd0, F_NONE);
    applyStimulus("add_bubble", 1, 5'd9, 1, 1, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("sub_invalid", 1, 5'd10, 0, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("setc", 1, 5'd1, 1, 0, 0, 10'b0000000010, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("unknown31", 1, 5'd31, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("unknown27", 1, 5'd27, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("in", 1, 5'd7, 1, 0, 0, 10'b1000001000, 5'd10, 2'b00, 2'd0, F_IN);
    applyStimulus("push", 1, 5'd15, 1, 0, 0, C_MW, 5'd11, 2'b01, 2'd0, F_PUSH);
    applyStimulus("jmp", 1, 5'd23, 1, 0, 0, 10'b0000000100, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("ldd", 1, 5'd18, 1, 0, 0, 10'b0010111000, 5'd1, 2'b00, 2'd0, F_NONE);

    // LDM: NOP, immediate cycle, back to IDLE decode
    applyStimulus("ldm_nop", 1, 5'd17, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("ldm_imm", 1, 5'd9, 1, 0, 0, C_LDMI, 5'd10, 2'b00, 2'd0, F_IMM);
    applyStimulus("ldm_after", 1, 5'd9, 1, 0, 0, C_ALU, 5'd1, 2'b00, 2'd0, F_NONE);
    // Bubble in LDM_IMM is ignored
    applyStimulus("ldm2_nop", 1, 5'd17, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("ldm2_imm_bub", 1, 5'd0, 0, 1, 0, C_LDMI, 5'd10, 2'b00, 2'd0, F_IMM);

    // CALL: two pushes, bubble ignored on the second
    applyStimulus("call_w0", 1, 5'd24, 1, 0, 0, C_CALL, 5'd11, 2'b01, 2'd0, F_HOLD);
    applyStimulus("call_w1_bub", 1, 5'd9, 1, 1, 0, C_MW, 5'd0, 2'b01, 2'd1, F_NONE);
    applyStimulus("call_after", 1, 5'd9, 1, 0, 0, C_ALU, 5'd1, 2'b00, 2'd0, F_NONE);

    // RTI: dispatch, pop 1, pop 0 (restore), two squash cycles, IDLE
    applyStimulus("rti_disp", 1, 5'd26, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("rti_pop1", 1, 5'd9, 1, 0, 0, C_MR, 5'd0, 2'b11, 2'd1, F_NONE);
    applyStimulus("rti_pop0", 1, 5'd9, 1, 0, 0, C_MR, 5'd0, 2'b11, 2'd0,
                  IRQ_EN ? F_CREST : F_NONE);
    applyStimulus("rti_sq0", 1, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_SQ);
    applyStimulus("rti_sq1", 1, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_SQ);
    applyStimulus("rti_after", 1, 5'd9, 1, 0, 0, C_ALU, 5'd1, 2'b00, 2'd0, F_NONE);

    // RET with irq pulsed during the first pop; serviced on the next IDLE cycle
    applyStimulus("ret_disp", 1, 5'd25, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("ret_pop1_irq", 1, 5'd9, 1, 0, 1, C_MR, 5'd0, 2'b11, 2'd1, F_NONE);
    applyStimulus("ret_pop0", 1, 5'd9, 1, 0, 0, C_MR, 5'd0, 2'b11, 2'd0, F_NONE);
    applyStimulus("ret_sq0", 1, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_SQ);
    applyStimulus("ret_sq1", 1, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_SQ);
    applyStimulus("pend_w0", 1, 5'd9, 1, 0, 0,
                  IRQ_EN ? C_MW : C_ALU, IRQ_EN ? 5'd0 : 5'd1,
                  IRQ_EN ? 2'b01 : 2'b00, 2'd0,
                  IRQ_EN ? (F_HOLD | F_CSAVE) : F_NONE);
    applyStimulus("pend_w1", 1, 5'd9, 1, 0, 0,
                  IRQ_EN ? C_MW : C_ALU, IRQ_EN ? 5'd0 : 5'd1,
                  IRQ_EN ? 2'b01 : 2'b00, IRQ_EN ? 2'd1 : 2'd0, F_NONE);
    applyStimulus("pend_after", 1, 5'd9, 1, 0, 0, C_ALU, 5'd1, 2'b00, 2'd0, F_NONE);

    // irq in IDLE beats a bubble and the opcode
    applyStimulus("irq_w0_bub", 1, 5'd9, 1, 1, 1,
                  IRQ_EN ? C_MW : C_ZERO, 5'd0, IRQ_EN ? 2'b01 : 2'b00, 2'd0,
                  IRQ_EN ? (F_HOLD | F_CSAVE) : F_NONE);
    applyStimulus("irq_w1", 1, 5'd9, 1, 0, 0,
                  IRQ_EN ? C_MW : C_ALU, IRQ_EN ? 5'd0 : 5'd1,
                  IRQ_EN ? 2'b01 : 2'b00, IRQ_EN ? 2'd1 : 2'd0, F_NONE);
    applyStimulus("irq_after", 1, 5'd9, 1, 0, 0, C_ALU, 5'd1, 2'b00, 2'd0, F_NONE);

    // Reset during the second CALL push abandons the sequence
    applyStimulus("call2_w0", 1, 5'd24, 1, 0, 0, C_CALL, 5'd11, 2'b01, 2'd0, F_HOLD);
    applyStimulus("call2_rst", 0, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("call2_rst_hold", 0, 5'd9, 1, 0, 0, C_ZERO, 5'd0, 2'b00, 2'd0, F_NONE);
    applyStimulus("post_rst_add", 1, 5'd9, 1, 0, 0, C_ALU, 5'd1, 2'b00, 2'd0, F_NONE);
    applyStimulus("post_rst_clrc", 1, 5'd2, 1, 0, 0, 10'b0000000001, 5'd0, 2'b00, 2'd0, F_NONE);

    // Let the monitor drain the queue, bounded
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
